mul_job_sequencer: RTL and testbench

Job controller wrapped around the 4x4 serial shift-add multiplier. Buffers operand pairs in a small FIFO and launches one multiplication at a time over the multiplier's s/A/B/Done/P interface. Captures each product into a valid/ready output register. Sits upstream of the multiplier, driving s, A and B, and downstream of it, consuming Done and P.

---
 rtl/mul_job_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mul_job_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_job_sequencer.sv
// Job sequencer for a serial shift-add multiplier: operand FIFO, s/A/B/Done/P launch FSM
// and a valid/ready product register. Optional RUN watchdog: define MUL_SEQ_WATCHDOG_EN.
module mul_job_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     mul_s,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_p,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("mul_job_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, RUN, RELEASE} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic                 mul_s_q, busy_q, out_valid_q;
  logic [WIDTH-1:0]     mul_a_q, mul_b_q;
  logic [2*WIDTH-1:0]   out_p_q;
  logic                 push, pop, slot_free, capture;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == IDLE) && (level_q != '0);
  assign slot_free = !out_valid_q || out_ready;
  assign capture   = (state_q == RUN) && mul_done && slot_free;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef MUL_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt_q;
  logic           timeout_err_q;
  logic           wd_expire;

  // Only cycles still waiting on the multiplier count; backpressure stalls do not.
  assign wd_expire = (state_q == RUN) && !mul_done && (wd_cnt_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wd_cnt_q <= '0;
    end else if (state_q == RUN && !mul_done && !wd_expire) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mul_s_q     <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
`ifdef MUL_SEQ_WATCHDOG_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef MUL_SEQ_WATCHDOG_EN
      timeout_err_q <= 1'b0;
`endif
      // A capture in the same cycle as a consumer handshake keeps out_valid high.
      if (capture) begin
        out_valid_q <= 1'b1;
        out_p_q     <= mul_p;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pop) begin
            {mul_a_q, mul_b_q} <= mem_q[rd_ptr_q];
            busy_q             <= 1'b1;
            state_q            <= SETUP;
          end
        end
        SETUP: begin
          mul_s_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (capture) begin
            mul_s_q <= 1'b0;
            state_q <= RELEASE;
          end
`ifdef MUL_SEQ_WATCHDOG_EN
          else if (wd_expire) begin
            mul_s_q       <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= RELEASE;
          end
`endif
        end
        RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_s     = mul_s_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = busy_q;
  assign level     = level_q;

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Bench for mul_job_sequencer with a behavioural serial shift-add multiplier attached.
// Watchdog scenario is compiled in with MUL_SEQ_WATCHDOG_EN.
module tb_mul_job_sequencer;
  localparam int W = 4;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0, in_b = '0;
  logic           mul_s;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_p;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_p;
  logic           busy;
  logic [$clog2(D):0] level;
  logic           timeout_err;

  always #5 clk = ~clk;

  mul_job_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_s(mul_s), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .busy(busy), .level(level),
    .timeout_err(timeout_err)
  );

  // Serial multiplier: idle loads A/B while s=0, W shift-add steps, then Done until s drops.
  logic           force_nodone = 1'b0;
  logic [1:0]     m_state;
  logic [2*W-1:0] m_a, m_acc;
  logic [W-1:0]   m_b;
  int             m_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 2'd0; m_a <= '0; m_b <= '0; m_acc <= '0; m_cnt <= 0;
    end else begin
      case (m_state)
        2'd0: begin
          m_a <= {{W{1'b0}}, mul_a}; m_b <= mul_b; m_acc <= '0; m_cnt <= 0;
          if (mul_s) m_state <= 2'd1;
        end
        2'd1: begin
          if (m_b[0]) m_acc <= m_acc + m_a;
          m_a <= m_a << 1; m_b <= m_b >> 1; m_cnt <= m_cnt + 1;
          if (m_cnt == W - 1) m_state <= 2'd2;
        end
        2'd2: if (!mul_s) m_state <= 2'd0;
        default: m_state <= 2'd0;
      endcase
    end
  end

  assign mul_done = (m_state == 2'd2) && !force_nodone;
  assign mul_p    = m_acc;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; int p; } vec_t;
  vec_t vecs [8];

  int total = 0, bad = 0;
  int exp_q[$];
  int cur_exp = 0;
  bit sb_skip = 1'b0;
  int n_out = 0, te_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs settled: records the handshakes of the next rising edge.
  task automatic tick();
    if (in_valid && in_ready && !sb_skip) exp_q.push_back(cur_exp);
    if (timeout_err) te_cnt++;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_product", int'(out_p), -1);
      else chk("product", int'(out_p), exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input int e);
    in_a = a; in_b = b; cur_exp = e; in_valid = 1'b1;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin tick(); w++; end
    repeat (4) tick();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_busy, n_s1, first_s, last_s, wt, w3, refused, found, stable, saved, t, bad_out;

    vecs[0] = '{4'd3,  4'd5,  15};
    vecs[1] = '{4'd15, 4'd15, 225};
    vecs[2] = '{4'd0,  4'd9,  0};
    vecs[3] = '{4'd1,  4'd1,  1};
    vecs[4] = '{4'd2,  4'd7,  14};
    vecs[5] = '{4'd15, 4'd1,  15};
    vecs[6] = '{4'd7,  4'd9,  63};
    vecs[7] = '{4'd12, 4'd11, 132};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_mul_s", int'(mul_s), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_p", int'(out_p), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    rst = 1'b1;
    tick();

    // single job and its mul_s framing
    out_ready = 1'b1;
    drive(4'd3, 4'd5, 15);
    tick();
    in_valid = 1'b0;
    n_busy = 0; n_s1 = 0; first_s = -1; last_s = -1;
    for (int i = 0; i < 60 && !(n_busy > 0 && !busy); i++) begin
      if (busy) begin
        if (n_busy == 0) first_s = int'(mul_s);
        last_s = int'(mul_s);
        n_busy++;
        if (mul_s) n_s1++;
      end
      tick();
    end
    chk("single_setup_s0", first_s, 0);
    chk("single_release_s0", last_s, 0);
    chk("single_run_len", n_s1, W + 2);
    chk("single_busy_len", n_busy, n_s1 + 2);
    chk("single_busy_end", int'(busy), 0);
    chk("single_level_end", int'(level), 0);
    chk("single_out_count", n_out, 1);
    chk("single_sb_empty", exp_q.size(), 0);

    // table vectors back to back
    w3 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].p);
      wt = 0;
      while (!in_ready && wt < 100) begin tick(); wt++; end
      if (i < 3) w3 += wt;
      tick();
    end
    in_valid = 1'b0;
    chk("backtoback_in_ready", w3, 0);
    drain("table_drain");

    // backpressure: fill the FIFO, stall in RUN, then release
    out_ready = 1'b0;
    refused = 0;
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].p);
      if (!in_ready) refused++;
      tick();
    end
    chk("fill_accepted", refused, 0);
    chk("fill_level", int'(level), 4);
    chk("fill_in_ready", int'(in_ready), 0);
    drive(vecs[5].a, vecs[5].b, vecs[5].p);
    tick();
    in_valid = 1'b0;
    chk("refuse_level", int'(level), 4);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (out_valid && mul_done && mul_s) found = 1;
      else tick();
    end
    chk("stall_reached", found, 1);
    stable = 0;
    for (int i = 0; i < 8; i++) begin
      if (mul_s && out_valid && busy && mul_done) stable++;
      tick();
    end
    chk("stall_stable", stable, 8);
    chk("stall_level", int'(level), 3);
    chk("stall_held_p", int'(out_p), vecs[0].p);
    out_ready = 1'b1;
    drain("bp_drain");

    // reset in the middle of RUN with a pair still queued
    drive(4'd9, 4'd9, 81);
    tick();
    drive(4'd5, 4'd5, 25);
    tick();
    in_valid = 1'b0;
    wt = 0;
    while (!mul_s && wt < 50) begin tick(); wt++; end
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("midrst_mul_s", int'(mul_s), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_busy", int'(busy), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    saved = n_out;
    repeat (20) tick();
    chk("midrst_no_product", n_out, saved);
    drive(4'd2, 4'd7, 14);
    tick();
    in_valid = 1'b0;
    drain("midrst_drain");

    // push on the same edge as the IDLE pop
    drive(4'd6, 4'd7, 42);
    tick();
    drive(4'd3, 4'd4, 12);
    tick();
    in_valid = 1'b0;
    chk("pushpop_level", int'(level), 1);
    chk("pushpop_busy", int'(busy), 1);
    drain("pushpop_drain");

`ifdef MUL_SEQ_WATCHDOG_EN
    force_nodone = 1'b1;
    sb_skip = 1'b1;
    drive(4'd4, 4'd4, 16);
    tick();
    in_valid = 1'b0;
    sb_skip = 1'b0;
    wt = 0;
    while (!mul_s && wt < 50) begin tick(); wt++; end
    t = 0; bad_out = 0;
    while (!timeout_err && t < 100) begin
      if (out_valid) bad_out++;
      tick(); t++;
    end
    chk("wd_latency", t, 32);
    chk("wd_no_out", bad_out, 0);
    force_nodone = 1'b0;
    repeat (4) tick();
    drive(4'd2, 4'd3, 6);
    tick();
    in_valid = 1'b0;
    drain("wd_drain");
    chk("timeout_pulses", te_cnt, 1);
`else
    chk("timeout_pulses", te_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
